serdes_push_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the push side of the serdes asymmetric FIFO. It shares the single FIFO push port between `NUM_REQ` requesters, each sending fixed-length packets of `PKT_LEN` words. The arbiter locks the grant for a whole packet and throttles on FIFO full. Optionally, it issues a flush after each packet so that a partial output word does not strand in the FIFO input buffer. It sits between the serdes packet sources and the FIFO's `push_req_n`, `data_i`, `flush_n`, `push_full_o` and `part_wd_o` pins.

---
 rtl/serdes_push_arbiter_if.sv | 47 ++++
 rtl/serdes_push_arbiter.sv | 144 ++++++++++++++
 tb/tb_serdes_push_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serdes_push_arbiter_if.sv
// Push-side bundle between the serdes packet sources, the arbiter
// and the asymmetric FIFO push pins.
interface serdes_push_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int REQ_LOG = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      fifo_push_req_n_o;
    logic [DATA_W-1:0]         fifo_data_o;
    logic                      fifo_flush_n_o;
    logic                      fifo_full_i;
    logic                      fifo_part_wd_i;
    logic [REQ_LOG-1:0]        grant_o;
    logic                      busy_o;
    logic                      pkt_done_o;

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  fifo_full_i,
        input  fifo_part_wd_i,
        output req_ready_o,
        output fifo_push_req_n_o,
        output fifo_data_o,
        output fifo_flush_n_o,
        output grant_o,
        output busy_o,
        output pkt_done_o
    );

    modport master (
        output req_valid_i,
        output req_data_i,
        output fifo_full_i,
        output fifo_part_wd_i,
        input  req_ready_o,
        input  fifo_push_req_n_o,
        input  fifo_data_o,
        input  fifo_flush_n_o,
        input  grant_o,
        input  busy_o,
        input  pkt_done_o
    );
endinterface

// File: rtl/serdes_push_arbiter.sv
// Round-robin packet arbiter for the serdes FIFO push port.
// Define SERDES_ARB_FLUSH_EN to flush partial words after each packet.
module serdes_push_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_LOG = 2,
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 4,
    parameter int PKT_LOG = 2
) (
    input logic                clk,
    input logic                reset,
    serdes_push_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        XFER,
        FLUSH
    } state_t;

    localparam logic [PKT_LOG-1:0] LAST = PKT_LOG'(PKT_LEN - 1);

    state_t             state;
    state_t             state_nxt;
    logic [REQ_LOG-1:0] grant_q;
    logic [REQ_LOG-1:0] last_grant;
    logic [REQ_LOG-1:0] pick;
    logic [REQ_LOG-1:0] rr_idx;
    logic               pick_vld;
    logic [PKT_LOG-1:0] beat_cnt;
    logic               done_q;
    logic               beat;
    logic               last_beat;
    logic               grant_now;
    logic [DATA_W-1:0]  words [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_word
        assign words[r] = bus.req_data_i[r*DATA_W +: DATA_W];
    end

    // Search upward from the requester after the last grant.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        rr_idx   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            rr_idx = REQ_LOG'((int'(last_grant) + i) % NUM_REQ);
            if (bus.req_valid_i[rr_idx]) begin
                pick     = rr_idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign grant_now = (state == IDLE) && pick_vld;
    assign beat      = (state == XFER) && bus.req_valid_i[grant_q]
                       && !bus.fifo_full_i;
    assign last_beat = beat && (beat_cnt == LAST);

`ifdef SERDES_ARB_FLUSH_EN
    logic flush_fire;

    // Next-state; the flush strobe fires on the FLUSH exit cycle.
    always_comb begin
        state_nxt  = state;
        flush_fire = 1'b0;
        unique case (state)
            IDLE: if (pick_vld) state_nxt = XFER;
            XFER: if (last_beat) state_nxt = FLUSH;
            FLUSH: begin
                if (!bus.fifo_full_i) begin
                    state_nxt  = IDLE;
                    flush_fire = bus.fifo_part_wd_i;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fifo_flush_n_o = !flush_fire;
`else
    logic unused_part_wd;

    assign unused_part_wd = bus.fifo_part_wd_i;

    // Next-state; the last beat returns straight to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (pick_vld) state_nxt = XFER;
            XFER: if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fifo_flush_n_o = 1'b1;
`endif

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant is locked for the whole packet once chosen in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q    <= '0;
            last_grant <= REQ_LOG'(NUM_REQ - 1);
        end else if (grant_now) begin
            grant_q    <= pick;
            last_grant <= pick;
        end
    end

    // Beat counter stays within the packet and restarts per grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (grant_now) begin
            beat_cnt <= '0;
        end else if (beat && !last_beat) begin
            beat_cnt <= beat_cnt + PKT_LOG'(1);
        end
    end

    // Done pulse is visible in the first IDLE cycle after a packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state != IDLE) && (state_nxt == IDLE);
        end
    end

    assign bus.req_ready_o       = beat ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.fifo_push_req_n_o = !beat;
    assign bus.fifo_data_o       = words[grant_q];
    assign bus.grant_o           = grant_q;
    assign bus.busy_o            = (state != IDLE);
    assign bus.pkt_done_o        = done_q;
endmodule

// File: tb/tb_serdes_push_arbiter.sv
// Self-checking bench for serdes_push_arbiter: directed scenarios
// plus a randomized run against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_serdes_push_arbiter;
    localparam int N    = 4;
    localparam int RL   = 2;
    localparam int DW   = 8;
    localparam int PL   = 4;
    localparam int PLOG = 2;
`ifdef SERDES_ARB_FLUSH_EN
    localparam int FL = 1;
`else
    localparam int FL = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  vld;
    logic [DW-1:0] word [N];
    logic          full;
    logic          part;
    int            checks = 0;
    int            errors = 0;

    serdes_push_arbiter_if #(.NUM_REQ(N), .REQ_LOG(RL), .DATA_W(DW)) bus();

    serdes_push_arbiter #(
        .NUM_REQ(N),
        .REQ_LOG(RL),
        .DATA_W (DW),
        .PKT_LEN(PL),
        .PKT_LOG(PLOG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.req_valid_i    = vld;
    assign bus.fifo_full_i    = full;
    assign bus.fifo_part_wd_i = part;

    always_comb begin
        bus.req_data_i = '0;
        for (int r = 0; r < N; r++) bus.req_data_i[r*DW +: DW] = word[r];
    end

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vld   = '0;
        full  = 1'b0;
        part  = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            next_cyc();
            for (int r = 0; r < N; r++) word[r] = 8'($urandom);
            #1;
            checks++;
            if ({bus.fifo_push_req_n_o, bus.fifo_flush_n_o, bus.req_ready_o,
                 bus.grant_o, bus.busy_o, bus.pkt_done_o} !== 10'b11_0000_00_00) begin
                errors++;
                $display("FAIL reset_outs c=%0d got pn=%b fn=%b rdy=%b g=%0d busy=%b done=%b",
                         c, bus.fifo_push_req_n_o, bus.fifo_flush_n_o, bus.req_ready_o,
                         bus.grant_o, bus.busy_o, bus.pkt_done_o);
            end
            checks++;
            if (bus.fifo_data_o !== word[0]) begin
                errors++;
                $display("FAIL reset_data c=%0d got %h exp %h", c, bus.fifo_data_o, word[0]);
            end
        end
    endtask

    task automatic test_single();
        int idx;
        int done_c;
        idx    = 0;
        done_c = 5 + FL;
        next_cyc();
        vld     = 4'b0010;
        word[1] = 8'hA0;
        for (int c = 0; c < 9; c++) begin
            #1;
            checks++;
            if (bus.fifo_push_req_n_o !== !(c >= 1 && c <= 4)) begin
                errors++;
                $display("FAIL single_push c=%0d got %b", c, bus.fifo_push_req_n_o);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (bus.fifo_data_o !== 8'(8'hA0 + c - 1) || bus.req_ready_o !== 4'b0010) begin
                    errors++;
                    $display("FAIL single_data c=%0d got %h/%b exp %h/0010",
                             c, bus.fifo_data_o, bus.req_ready_o, 8'(8'hA0 + c - 1));
                end
            end
            checks++;
            if (bus.pkt_done_o !== (c == done_c)) begin
                errors++;
                $display("FAIL single_done c=%0d got %b exp %b", c, bus.pkt_done_o, c == done_c);
            end
            if (c >= 1) begin
                checks++;
                if (bus.grant_o !== 2'd1) begin
                    errors++;
                    $display("FAIL single_grant c=%0d got %0d exp 1", c, bus.grant_o);
                end
            end
            if (bus.req_ready_o[1]) idx++;
            next_cyc();
            if (idx >= 4) vld = '0;
            else word[1] = 8'(8'hA0 + idx);
        end
    endtask

    task automatic test_two_req();
        int order [4] = '{0, 2, 0, 2};
        int cnt0;
        int cnt2;
        int pushes;
        int own;
        int budget;
        logic [DW-1:0] exp_d;
        do_reset();
        cnt0 = 0;
        cnt2 = 0;
        pushes = 0;
        budget = 0;
        next_cyc();
        vld     = 4'b0101;
        word[0] = 8'h10;
        word[2] = 8'h30;
        while (pushes < 16 && budget < 100) begin
            #1;
            own   = order[pushes / 4];
            exp_d = 8'((own == 0 ? 8'h10 : 8'h30) + (pushes / 8) * 4 + pushes % 4);
            checks++;
            if (!bus.fifo_push_req_n_o) begin
                if (bus.req_ready_o !== 4'(1 << own) || bus.fifo_data_o !== exp_d) begin
                    errors++;
                    $display("FAIL rr_push n=%0d got rdy=%b d=%h exp rdy=%b d=%h",
                             pushes, bus.req_ready_o, bus.fifo_data_o, 4'(1 << own), exp_d);
                end
                pushes++;
            end else if (bus.req_ready_o !== 4'b0000) begin
                errors++;
                $display("FAIL rr_idle_ready n=%0d got %b exp 0000", pushes, bus.req_ready_o);
            end
            if (bus.req_ready_o[0]) cnt0++;
            if (bus.req_ready_o[2]) cnt2++;
            next_cyc();
            word[0] = 8'(8'h10 + cnt0);
            word[2] = 8'(8'h30 + cnt2);
            budget++;
        end
        checks++;
        if (pushes != 16) begin
            errors++;
            $display("FAIL rr_timeout got %0d pushes exp 16", pushes);
        end
        vld = '0;
    endtask

    task automatic test_full_stall();
        int idx;
        int done_c;
        bit exp_push;
        logic [DW-1:0] exp_d;
        idx    = 0;
        done_c = 8 + FL;
        do_reset();
        next_cyc();
        vld     = 4'b1000;
        word[3] = 8'hC0;
        for (int c = 0; c < 11; c++) begin
            full = (c >= 3 && c <= 5);
            #1;
            exp_push = (c == 1 || c == 2 || c == 6 || c == 7);
            exp_d    = 8'(8'hC0 + (c <= 2 ? c - 1 : c - 4));
            checks++;
            if (bus.fifo_push_req_n_o !== !exp_push
                || bus.req_ready_o !== (exp_push ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("FAIL stall_push c=%0d got pn=%b rdy=%b exp pn=%b",
                         c, bus.fifo_push_req_n_o, bus.req_ready_o, !exp_push);
            end
            if (exp_push) begin
                checks++;
                if (bus.fifo_data_o !== exp_d || bus.grant_o !== 2'd3) begin
                    errors++;
                    $display("FAIL stall_data c=%0d got %h g=%0d exp %h g=3",
                             c, bus.fifo_data_o, bus.grant_o, exp_d);
                end
            end
            checks++;
            if (bus.pkt_done_o !== (c == done_c)) begin
                errors++;
                $display("FAIL stall_done c=%0d got %b exp %b", c, bus.pkt_done_o, c == done_c);
            end
            if (bus.req_ready_o[3]) idx++;
            next_cyc();
            if (idx >= 4) vld = '0;
            else word[3] = 8'(8'hC0 + idx);
        end
        full = 1'b0;
    endtask

    task automatic test_flush();
        int idx;
        int flushes;
        int flush_at;
        int done_c;
        int exp_fl;
        do_reset();
        for (int t = 0; t < 2; t++) begin
            idx      = 0;
            flushes  = 0;
            flush_at = -1;
            done_c   = (FL == 1) ? (t == 0 ? 8 : 6) : 5;
            exp_fl   = (FL == 1 && t == 0) ? 1 : 0;
            next_cyc();
            vld     = 4'b0001;
            word[0] = 8'h50;
            part    = (t == 0);
            for (int c = 0; c < 11; c++) begin
                full = (t == 0) && (c == 5 || c == 6);
                #1;
                if (!bus.fifo_flush_n_o) begin
                    flushes++;
                    flush_at = c;
                end
                checks++;
                if (bus.pkt_done_o !== (c == done_c)) begin
                    errors++;
                    $display("FAIL flush_done t=%0d c=%0d got %b exp %b",
                             t, c, bus.pkt_done_o, c == done_c);
                end
                if (bus.req_ready_o[0]) idx++;
                next_cyc();
                if (idx >= 4) vld = '0;
                else word[0] = 8'(8'h50 + idx);
            end
            checks++;
            if (flushes != exp_fl || (exp_fl == 1 && flush_at != 7)) begin
                errors++;
                $display("FAIL flush_count t=%0d got %0d at %0d exp %0d at 7",
                         t, flushes, flush_at, exp_fl);
            end
        end
        full = 1'b0;
        part = 1'b0;
    endtask

    task automatic test_mid_reset();
        int k;
        bit seen;
        do_reset();
        next_cyc();
        vld     = 4'b0100;
        word[2] = 8'h70;
        word[0] = 8'h90;
        next_cyc();
        #1;
        checks++;
        if (bus.fifo_push_req_n_o !== 1'b0 || bus.fifo_data_o !== 8'h70) begin
            errors++;
            $display("FAIL mrst_beat1 got pn=%b d=%h exp 0/70", bus.fifo_push_req_n_o, bus.fifo_data_o);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus.fifo_push_req_n_o, bus.fifo_flush_n_o, bus.req_ready_o,
             bus.grant_o, bus.busy_o, bus.pkt_done_o} !== 10'b11_0000_00_00
            || bus.fifo_data_o !== word[0]) begin
            errors++;
            $display("FAIL mrst_async got pn=%b rdy=%b g=%0d busy=%b d=%h",
                     bus.fifo_push_req_n_o, bus.req_ready_o, bus.grant_o,
                     bus.busy_o, bus.fifo_data_o);
        end
        next_cyc();
        reset = 1'b0;
        vld   = 4'b0101;
        k     = 0;
        seen  = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (!bus.fifo_push_req_n_o) begin
                checks++;
                if (bus.req_ready_o !== 4'b0001 || bus.fifo_data_o !== 8'(8'h90 + k)) begin
                    errors++;
                    $display("FAIL mrst_push k=%0d got rdy=%b d=%h exp 0001/%h",
                             k, bus.req_ready_o, bus.fifo_data_o, 8'(8'h90 + k));
                end
                k++;
            end
            if (bus.pkt_done_o) seen = 1;
            next_cyc();
            word[0] = 8'(8'h90 + k);
        end
        checks++;
        if (!seen || k != 4) begin
            errors++;
            $display("FAIL mrst_pkt got done=%b beats=%0d exp 1/4", seen, k);
        end
        vld = '0;
    endtask

    task automatic test_random();
        bit            m_busy;
        bit            m_fl;
        bit            m_done;
        bit            nd;
        bit            found;
        bit            bt;
        bit            e_fn;
        int            m_last;
        int            m_sent;
        logic [RL-1:0] m_grant;
        logic [RL-1:0] ix;
        logic [N-1:0]  e_rdy;
        do_reset();
        m_busy  = 0;
        m_fl    = 0;
        m_done  = 0;
        m_last  = N - 1;
        m_sent  = 0;
        m_grant = '0;
        for (int c = 0; c < 3000; c++) begin
            next_cyc();
            vld  = N'($urandom);
            full = ($urandom_range(3) == 0);
            part = 1'($urandom_range(1));
            for (int r = 0; r < N; r++) word[r] = 8'($urandom);
            #1;
            bt    = m_busy && !m_fl && vld[m_grant] && !full;
            e_rdy = bt ? N'(1 << m_grant) : '0;
            e_fn  = !(FL == 1 && m_fl && !full && part);
            checks++;
            if (bus.req_ready_o !== e_rdy || bus.fifo_push_req_n_o !== !bt
                || bus.fifo_data_o !== word[m_grant]) begin
                errors++;
                $display("FAIL rand_push c=%0d got rdy=%b pn=%b d=%h exp rdy=%b pn=%b d=%h",
                         c, bus.req_ready_o, bus.fifo_push_req_n_o, bus.fifo_data_o,
                         e_rdy, !bt, word[m_grant]);
            end
            checks++;
            if (bus.grant_o !== m_grant || bus.busy_o !== m_busy
                || bus.pkt_done_o !== m_done || bus.fifo_flush_n_o !== e_fn) begin
                errors++;
                $display("FAIL rand_ctl c=%0d got g=%0d b=%b dn=%b fn=%b exp g=%0d b=%b dn=%b fn=%b",
                         c, bus.grant_o, bus.busy_o, bus.pkt_done_o, bus.fifo_flush_n_o,
                         m_grant, m_busy, m_done, e_fn);
            end
            nd = 0;
            if (!m_busy) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    ix = RL'((m_last + k) % N);
                    if (!found && vld[ix]) begin
                        found   = 1;
                        m_grant = ix;
                    end
                end
                if (found) begin
                    m_busy = 1;
                    m_last = int'(m_grant);
                    m_sent = 0;
                end
            end else if (!m_fl) begin
                if (bt) begin
                    m_sent++;
                    if (m_sent == PL) begin
                        if (FL == 1) m_fl = 1;
                        else begin
                            m_busy = 0;
                            nd     = 1;
                        end
                    end
                end
            end else if (!full) begin
                m_fl   = 0;
                m_busy = 0;
                nd     = 1;
            end
            m_done = nd;
        end
        vld  = '0;
        full = 1'b0;
        part = 1'b0;
    endtask

    initial begin
        vld  = '0;
        full = 1'b0;
        part = 1'b0;
        for (int r = 0; r < N; r++) word[r] = '0;
        test_reset();
        test_single();
        test_two_req();
        test_full_stall();
        test_flush();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
